// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK/timeout reporting
module ps2_host_tx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int INH = CLK_FREQ / 1000000 * INHIBIT_US;
  localparam int TO  = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int CW  = $clog2(TO + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INH - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev, fall;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    data, data_n;
  logic          parity, parity_n, ack_bit, ack_bit_n;
  logic          done_n, ack_err_n, clk_oe_n, dat_oe_n;

  assign fall = clk_prev & ~clk_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_prev   <= 1'b1;
      cnt        <= '0;
      bitcnt     <= '0;
      data       <= '0;
      parity     <= 1'b0;
      ack_bit    <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_n;
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      dat_sync   <= {dat_sync[0], ps2_dat_in};
      clk_prev   <= clk_sync[1];
      cnt        <= cnt_n;
      bitcnt     <= bitcnt_n;
      data       <= data_n;
      parity     <= parity_n;
      ack_bit    <= ack_bit_n;
      tx_ready   <= state_n == IDLE;
      busy       <= state_n != IDLE;
      done       <= done_n;
      ack_err    <= ack_err_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
    end
  end

  // Falls outside SEND are simply never looked at, so INHIBIT/RTS ignore them.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bitcnt_n  = bitcnt;
    data_n    = data;
    parity_n  = parity;
    ack_bit_n = ack_bit;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    clk_oe_n  = 1'b0;
    dat_oe_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n  = INHIBIT;
          data_n   = tx_data;
          parity_n = ~^tx_data;
          cnt_n    = '0;
          clk_oe_n = 1'b1;
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        cnt_n    = cnt + 1'b1;
        if (cnt == INH_LAST) begin
          state_n  = RTS;
          dat_oe_n = 1'b1;
        end
      end
      RTS: begin
        state_n  = SEND;
        dat_oe_n = 1'b1;
        cnt_n    = '0;
        bitcnt_n = '0;
      end
      SEND: begin
        cnt_n    = cnt + 1'b1;
        dat_oe_n = ps2_dat_oe;
        if (cnt == TO_LAST) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          ack_err_n = 1'b1;
          dat_oe_n  = 1'b0;
        end else if (fall) begin
          bitcnt_n = bitcnt + 4'd1;
          dat_oe_n = (bitcnt < 4'd8) ? ~data[bitcnt[2:0]] : (bitcnt == 4'd8) ? ~parity : 1'b0;
          if (bitcnt == 4'd10) begin
            state_n   = WAIT_IDLE;
            ack_bit_n = dat_sync[1];
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == TO_LAST) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          ack_err_n = 1'b1;
        end else if (clk_sync[1] && dat_sync[1]) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          ack_err_n = ack_bit;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
